link_tx_serializer: RTL and testbench

//  Drains one Tx Packet_Queue (N/S/W/E) written by Routing_State_Machine and sends each 32-bit packet
//  to the neighbouring router as PACKET_WIDTH/LINK_WIDTH beats on a narrow link, using valid/ready.
//  One instance per link direction, directly downstream of that direction's Tx queue.

---
 rtl/link_tx_serializer.sv | 103 ++++++++++
 tb/tb_link_tx_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/link_tx_serializer.sv
// Drains one Tx packet queue and serialises each packet MSB-slice-first onto a
// narrow valid/ready link, one packet per BEATS+1 cycles at full ready.
module link_tx_serializer #(
    parameter int PACKET_WIDTH = 32,
    parameter int LINK_WIDTH   = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    Clk_r,
    input  logic                    Rst,
    input  logic                    Link_Enable,
    input  logic                    TxQueue_Empty,
    input  logic [PACKET_WIDTH-1:0] TxQueue_Packet,
    output logic                    TxQueue_Read,
    output logic [LINK_WIDTH-1:0]   Link_Data,
    output logic                    Link_Valid,
    output logic                    Link_Start,
    output logic                    Link_Last,
    input  logic                    Link_Ready,
    output logic                    Busy,
    output logic [CNT_WIDTH-1:0]    Packets_Sent
);

    localparam int BEATS      = PACKET_WIDTH / LINK_WIDTH;
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PACKET_WIDTH-1:0] shift_reg;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic                    load;
    logic                    accept;
    logic                    last_beat;

    // Link handshake: a beat transfers on a rising edge where Link_Valid and
    // Link_Ready are both 1; while Link_Valid=1 and Link_Ready=0 the beat and
    // its Start/Last flags hold unchanged, with no timeout.
    assign load      = (state == IDLE) && Link_Enable && !TxQueue_Empty;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign accept    = (state == SEND) && Link_Ready;

    always_ff @(posedge Clk_r) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = SEND;
            SEND: if (accept && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Link_Valid = 1'b0;
        Busy       = 1'b0;
        Link_Start = 1'b0;
        Link_Last  = 1'b0;
        Link_Data  = '0;
        if (state == SEND) begin
            Link_Valid = 1'b1;
            Busy       = 1'b1;
            Link_Start = (beat_cnt == '0);
            Link_Last  = last_beat;
            Link_Data  = shift_reg[PACKET_WIDTH-1 -: LINK_WIDTH];
        end
    end

    // The pop is registered so it lands in the first SEND cycle; the queue
    // head has already been captured, and the next load cannot happen before
    // the queue has reflected this pop.
    always_ff @(posedge Clk_r) begin
        if (Rst) begin
            shift_reg    <= '0;
            beat_cnt     <= '0;
            TxQueue_Read <= 1'b0;
            Packets_Sent <= '0;
        end else begin
            TxQueue_Read <= load;
            if (load) begin
                shift_reg <= TxQueue_Packet;
                beat_cnt  <= '0;
            end else if (accept) begin
                shift_reg <= shift_reg << LINK_WIDTH;
                beat_cnt  <= beat_cnt + BEAT_CNT_W'(1);
                if (last_beat) begin
                    Packets_Sent <= Packets_Sent + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_link_tx_serializer.sv
// Directed bench for link_tx_serializer: a queue model feeds the DUT and each
// step samples outputs on the falling edge against hand-computed beats.
module tb_link_tx_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_enable;
    logic        tx_empty;
    logic [31:0] tx_packet;
    logic        tx_read;
    logic [7:0]  link_data;
    logic        link_valid;
    logic        link_start;
    logic        link_last;
    logic        link_ready;
    logic        busy;
    logic [15:0] packets_sent;

    logic        n_tx_read;
    logic [7:0]  n_link_data;
    logic        n_link_valid;
    logic        n_link_start;
    logic        n_link_last;
    logic        n_busy;
    logic [2:0]  n_packets_sent;

    logic [31:0] q[$];
    int          tests = 0;
    int          fails = 0;
    int          pops  = 0;

    always #5 clk = ~clk;

    link_tx_serializer dut (
        .Clk_r(clk), .Rst(rst), .Link_Enable(link_enable),
        .TxQueue_Empty(tx_empty), .TxQueue_Packet(tx_packet), .TxQueue_Read(tx_read),
        .Link_Data(link_data), .Link_Valid(link_valid), .Link_Start(link_start),
        .Link_Last(link_last), .Link_Ready(link_ready), .Busy(busy),
        .Packets_Sent(packets_sent)
    );

    // Narrow counter copy sees identical inputs so counter wrap is reachable quickly.
    link_tx_serializer #(.CNT_WIDTH(3)) dut_narrow (
        .Clk_r(clk), .Rst(rst), .Link_Enable(link_enable),
        .TxQueue_Empty(tx_empty), .TxQueue_Packet(tx_packet), .TxQueue_Read(n_tx_read),
        .Link_Data(n_link_data), .Link_Valid(n_link_valid), .Link_Start(n_link_start),
        .Link_Last(n_link_last), .Link_Ready(link_ready), .Busy(n_busy),
        .Packets_Sent(n_packets_sent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        tx_empty  = (q.size() == 0);
        tx_packet = (q.size() > 0) ? q[0] : 32'h0;
    endtask

    task automatic push(input logic [31:0] p);
        q.push_back(p);
        refresh();
    endtask

    // One clock: apply the pop the DUT requested this cycle, then sample on the falling edge.
    task automatic step();
        @(posedge clk);
        if (tx_read) begin
            chk("pop_nonempty", {31'b0, q.size() > 0}, 32'd1);
            if (q.size() > 0) q.delete(0);
            pops++;
        end
        #1;
        refresh();
        @(negedge clk);
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic s, input logic l);
        chk({tag, "_valid"}, {31'b0, link_valid}, 32'd1);
        chk({tag, "_data"},  {24'b0, link_data},  {24'b0, d});
        chk({tag, "_start"}, {31'b0, link_start}, {31'b0, s});
        chk({tag, "_last"},  {31'b0, link_last},  {31'b0, l});
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_valid"}, {31'b0, link_valid}, 32'd0);
        chk({tag, "_busy"},  {31'b0, busy},       32'd0);
        chk({tag, "_data"},  {24'b0, link_data},  32'd0);
    endtask

    // Runs n samples over packets sent back-to-back: 4 beats then one idle bubble each.
    task automatic stream(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] p2, input int n);
        logic [31:0] pk;
        int          b;
        for (int k = 0; k < n; k++) begin
            step();
            pk = (k / 5 == 0) ? p0 : (k / 5 == 1) ? p1 : p2;
            b  = k % 5;
            if (b == 4) idle_chk(tag);
            else beat(tag, 8'((pk >> (24 - 8 * b)) & 32'hFF), b == 0, b == 3);
        end
    endtask

    task automatic send_pkt(input logic [31:0] p);
        push(p);
        repeat (5) step();
    endtask

    int pops_before;

    initial begin
        rst = 1'b1; link_enable = 1'b0; link_ready = 1'b0;
        refresh();
        repeat (3) step();
        rst = 1'b0;
        step();
        idle_chk("reset");
        chk("reset_read",  {31'b0, tx_read},    32'd0);
        chk("reset_start", {31'b0, link_start}, 32'd0);
        chk("reset_last",  {31'b0, link_last},  32'd0);
        chk("reset_sent",  {16'b0, packets_sent}, 32'd0);

        // 1: single packet at full ready
        link_enable = 1'b1; link_ready = 1'b1;
        push(32'h3300DEAD);
        step(); beat("t1_b0", 8'h33, 1, 0); chk("t1_read0", {31'b0, tx_read}, 32'd1);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        step(); beat("t1_b1", 8'h00, 0, 0); chk("t1_read1", {31'b0, tx_read}, 32'd0);
        step(); beat("t1_b2", 8'hDE, 0, 0);
        step(); beat("t1_b3", 8'hAD, 0, 1);
        step(); idle_chk("t1_end");
        chk("t1_sent", {16'b0, packets_sent}, 32'd1);
        chk("t1_pops", pops, 32'd1);

        // 2: stall on the first beat
        link_ready = 1'b0;
        push(32'hDEADBEEF);
        step(); beat("t2_b0", 8'hDE, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(); beat("t2_hold", 8'hDE, 1, 0);
            chk("t2_empty", {31'b0, tx_empty}, 32'd1);
        end
        link_ready = 1'b1;
        step(); beat("t2_b1", 8'hAD, 0, 0);
        step(); beat("t2_b2", 8'hBE, 0, 0);
        step(); beat("t2_b3", 8'hEF, 0, 1);
        step(); idle_chk("t2_end");
        chk("t2_sent", {16'b0, packets_sent}, 32'd2);

        // 3: three packets back-to-back, 12 beats in 15 cycles
        pops_before = pops;
        push(32'h11223344); push(32'h55667788); push(32'h99AABBCC);
        stream("t3", 32'h11223344, 32'h55667788, 32'h99AABBCC, 15);
        chk("t3_pops", pops - pops_before, 32'd3);
        chk("t3_sent", {16'b0, packets_sent}, 32'd5);

        // 4: link disabled with two queued packets
        link_enable = 1'b0;
        pops_before = pops;
        push(32'hA1B2C3D4); push(32'hE5F6A7B8);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_off_valid", {31'b0, link_valid}, 32'd0);
            chk("t4_off_read",  {31'b0, tx_read},    32'd0);
        end
        chk("t4_off_pops", pops - pops_before, 32'd0);
        link_enable = 1'b1;
        stream("t4", 32'hA1B2C3D4, 32'hE5F6A7B8, 32'h0, 10);
        chk("t4_sent", {16'b0, packets_sent}, 32'd7);

        push(32'h01020304); push(32'h05060708);
        step(); beat("t4d_b0", 8'h01, 1, 0);
        step(); beat("t4d_b1", 8'h02, 0, 0);
        link_enable = 1'b0;
        step(); beat("t4d_b2", 8'h03, 0, 0);
        step(); beat("t4d_b3", 8'h04, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4d_held_valid", {31'b0, link_valid}, 32'd0);
            chk("t4d_held_read",  {31'b0, tx_read},    32'd0);
        end
        chk("t4d_queued", q.size(), 32'd1);
        chk("t4d_sent", {16'b0, packets_sent}, 32'd8);
        chk("t4d_narrow_wrap", {29'b0, n_packets_sent}, 32'd0);
        link_enable = 1'b1;
        step(); beat("t4e_b0", 8'h05, 1, 0);
        step(); beat("t4e_b1", 8'h06, 0, 0);
        step(); beat("t4e_b2", 8'h07, 0, 0);
        step(); beat("t4e_b3", 8'h08, 0, 1);
        step(); idle_chk("t4e_end");
        chk("t4e_sent", {16'b0, packets_sent}, 32'd9);
        chk("t4e_narrow", {29'b0, n_packets_sent}, 32'd1);

        // 5: reset mid-packet drops it; next packet starts from its first beat
        push(32'hCAFEF00D); push(32'h12345678);
        step(); beat("t5_b0", 8'hCA, 1, 0);
        step(); beat("t5_b1", 8'hFE, 0, 0);
        rst = 1'b1;
        step();
        idle_chk("t5_rst");
        chk("t5_rst_sent", {16'b0, packets_sent}, 32'd0);
        chk("t5_rst_read", {31'b0, tx_read}, 32'd0);
        chk("t5_rst_start", {31'b0, link_start}, 32'd0);
        chk("t5_queued", q.size(), 32'd1);
        rst = 1'b0;
        step(); beat("t5n_b0", 8'h12, 1, 0); chk("t5n_read", {31'b0, tx_read}, 32'd1);
        step(); beat("t5n_b1", 8'h34, 0, 0);
        step(); beat("t5n_b2", 8'h56, 0, 0);
        step(); beat("t5n_b3", 8'h78, 0, 1);
        step(); idle_chk("t5n_end");
        chk("t5n_sent", {16'b0, packets_sent}, 32'd1);

        // 6: counter wrap on the narrow instance (7 -> 0)
        for (int i = 0; i < 6; i++) send_pkt(32'h0F0F0000 + i);
        chk("t6_sent7", {16'b0, packets_sent}, 32'd7);
        chk("t6_narrow7", {29'b0, n_packets_sent}, 32'd7);
        send_pkt(32'hFFFFFFFF);
        chk("t6_sent8", {16'b0, packets_sent}, 32'd8);
        chk("t6_narrow_wrap", {29'b0, n_packets_sent}, 32'd0);
        chk("t6_empty", {31'b0, tx_empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
